// File: rtl/mmio_timer_pkg.sv
// Shared register map and helpers for the memory-mapped timer.
// Holds offset codes, CTRL bit indices and the byte-lane merge.
package mmio_timer_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_COUNT    = 3'd2;
  localparam logic [2:0] REG_COMPARE  = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old_v,
    input logic [31:0] wdat,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = sel[i] ? wdat[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// CPU data-port bundle seen by the timer.
// The master drives the request, the slave returns read data.
interface mmio_timer_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (
    output ce, we, addr, sel, data_i,
    input  data_o
  );

  modport slave (
    input  ce, we, addr, sel, data_i,
    output data_o
  );
endinterface

// File: rtl/mmio_timer_prescaler.sv
// Prescaler for the timer: emits a one-cycle tick every
// prescale+1 enabled cycles; the counter idles at 0 when disabled.
module timer_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] prescale,
  output logic               tick
);

  logic [PRESC_W-1:0] pcnt_q, pcnt_d;

  assign tick = en && (pcnt_q == prescale);

  always_comb begin
    pcnt_d = '0;
    if (en && !tick) begin
      pcnt_d = pcnt_q + {{(PRESC_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pcnt_q <= '0;
    else     pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped compare timer with auto-reload and a level IRQ.
// Registers: CTRL, STATUS, COUNT, COMPARE, PRESCALE at addr[4:2].
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter int PRESC_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  mmio_timer_if.slave  bus,
  output logic         int_o
);

  logic [2:0]         ctrl_q, ctrl_d;
  logic               match_q, match_d;
  logic [31:0]        count_q, count_d;
  logic [31:0]        compare_q, compare_d;
  logic [PRESC_W-1:0] prescale_q, prescale_d;

  logic       tick, hit, wr, rd;
  logic [2:0] a;
  logic       unused_addr;

  assign wr = bus.ce & bus.we;
  assign rd = bus.ce & ~bus.we;
  assign a  = bus.addr[4:2];
  assign unused_addr = ^{bus.addr[31:5], bus.addr[1:0]};

  timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl_q[CTRL_EN]),
    .prescale (prescale_q),
    .tick     (tick)
  );

  // Compare uses the pre-write COMPARE value.
  assign hit = tick && (count_q == compare_q);

  always_comb begin
    ctrl_d     = ctrl_q;
    match_d    = match_q;
    count_d    = count_q;
    compare_d  = compare_q;
    prescale_d = prescale_q;

    if (tick) begin
      count_d = (hit && ctrl_q[CTRL_AUTO]) ? 32'h0 : count_q + 32'h1;
    end

    if (wr) begin
      unique case (a)
        REG_CTRL: if (bus.sel[0]) ctrl_d = bus.data_i[2:0];
        REG_STATUS: begin
          if (bus.sel[0] && bus.data_i[0]) match_d = 1'b0;
        end
        REG_COUNT:
          count_d = byte_merge(count_q, bus.data_i, bus.sel);
        REG_COMPARE:
          compare_d = byte_merge(compare_q, bus.data_i, bus.sel);
        REG_PRESCALE:
          prescale_d = PRESC_W'(byte_merge(32'(prescale_q),
                                           bus.data_i, bus.sel));
        default: ;
      endcase
    end

    // A new match beats a same-cycle clear.
    if (hit) match_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      match_q    <= 1'b0;
      count_q    <= '0;
      compare_q  <= '0;
      prescale_q <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      match_q    <= match_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      prescale_q <= prescale_d;
    end
  end

  always_comb begin
    bus.data_o = 32'h0;
    if (rd) begin
      unique case (a)
        REG_CTRL:     bus.data_o = {29'h0, ctrl_q};
        REG_STATUS:   bus.data_o = {31'h0, match_q};
        REG_COUNT:    bus.data_o = count_q;
        REG_COMPARE:  bus.data_o = compare_q;
        REG_PRESCALE: bus.data_o = 32'(prescale_q);
        default:      bus.data_o = 32'h0;
      endcase
    end
  end

  assign int_o = match_q & ctrl_q[CTRL_IE];

endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: directed scenarios plus random traffic
// checked against a cycle-level arithmetic model of the register rules.
module tb_mmio_timer;
  import mmio_timer_pkg::*;

  localparam int PW = 16;

  logic clk = 1'b0;
  logic rst;
  logic int_o;

  mmio_timer_if bus();

  mmio_timer #(.PRESC_W(PW)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .int_o (int_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [2:0]    m_ctrl;
  logic          m_match;
  logic [31:0]   m_count, m_compare;
  logic [PW-1:0] m_presc;
  longint        m_age;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return {29'h0, m_ctrl};
      3'd1:    return {31'h0, m_match};
      3'd2:    return m_count;
      3'd3:    return m_compare;
      3'd4:    return 32'(m_presc);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_match = 0; m_count = '0;
    m_compare = '0; m_presc = '0; m_age = 0;
  endtask

  // m_age counts enabled cycles; PRESCALE is only changed while
  // disabled, so tick timing is a plain modulo of that age.
  task automatic model_step(input logic c, input logic w,
                            input logic [31:0] ad, input logic [3:0] s,
                            input logic [31:0] d, input logic r);
    logic        tick, hit, old_en;
    logic [31:0] mask, old_count;
    logic [2:0]  a;
    if (r) begin
      model_reset();
      return;
    end
    old_en    = m_ctrl[0];
    old_count = m_count;
    tick = old_en &&
           ((m_age % (longint'(m_presc) + 1)) == longint'(m_presc));
    hit  = tick && (m_count == m_compare);
    mask = lanes(s);
    a    = ad[4:2];
    if (tick) m_count = (hit && m_ctrl[1]) ? 32'h0 : m_count + 1;
    if (c && w) begin
      case (a)
        3'd0: if (s[0]) m_ctrl = d[2:0];
        3'd1: if (s[0] && d[0]) m_match = 0;
        3'd2: m_count = (old_count & ~mask) | (d & mask);
        3'd3: m_compare = (m_compare & ~mask) | (d & mask);
        3'd4: m_presc = PW'((32'(m_presc) & ~mask) | (d & mask));
        default: ;
      endcase
    end
    if (hit) m_match = 1;
    m_age = old_en ? m_age + 1 : 0;
  endtask

  task automatic cyc(input logic c, input logic w,
                     input logic [31:0] ad, input logic [3:0] s,
                     input logic [31:0] d, input logic r,
                     output logic [31:0] od, output logic oi);
    rst = r;
    bus.ce = c; bus.we = w; bus.addr = ad;
    bus.sel = s; bus.data_i = d;
    #3;
    od = bus.data_o;
    oi = int_o;
    if (c && !w) chk("rd_model", od, m_read(ad[4:2]));
    else         chk("idle_zero", od, 32'h0);
    chk("int_model", {31'h0, oi}, {31'h0, m_match & m_ctrl[2]});
    @(posedge clk);
    model_step(c, w, ad, s, d, r);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    logic [31:0] od;
    logic        oi;
    cyc(1, 1, {27'h0, a, 2'b00}, s, d, 0, od, oi);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] od,
                    output logic oi);
    cyc(1, 0, {27'h0, a, 2'b00}, 4'hf, 32'h0, 0, od, oi);
  endtask

  task automatic rst_cyc();
    logic [31:0] od;
    logic        oi;
    cyc(0, 0, 32'h0, 4'h0, 32'h0, 1, od, oi);
  endtask

  logic [31:0] obs;
  logic        oi;
  logic [31:0] exp_ar [5] = '{0, 1, 2, 3, 0};
  logic        exp_ai [5] = '{0, 0, 0, 0, 1};
  logic [31:0] exp_ps [7] = '{0, 0, 0, 1, 1, 1, 2};

  initial begin
    rst = 1'b1;
    bus.ce = 0; bus.we = 0; bus.addr = '0;
    bus.sel = '0; bus.data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_cyc();
    rst_cyc();

    for (int i = 0; i < 8; i++) begin
      rd(3'(i), obs, oi);
      chk("reset_reg", obs, 32'h0);
    end
    chk("reset_int", {31'h0, oi}, 32'h0);

    wr(3'd3, 32'hAABBCCDD, 4'b0101);
    rd(3'd3, obs, oi);
    chk("byte_lane", obs, 32'h00BB00DD);

    wr(3'd4, 32'h0, 4'hf);
    wr(3'd3, 32'h3, 4'hf);
    wr(3'd2, 32'h0, 4'hf);
    wr(3'd0, 32'h7, 4'hf);
    for (int i = 0; i < 5; i++) begin
      rd(3'd2, obs, oi);
      chk("auto_count", obs, exp_ar[i]);
      chk("auto_int", {31'h0, oi}, {31'h0, exp_ai[i]});
    end
    wr(3'd0, 32'h0, 4'hf);
    wr(3'd1, 32'h1, 4'hf);
    rd(3'd1, obs, oi);
    chk("w1c_clear", obs, 32'h0);

    rst_cyc();
    wr(3'd4, 32'h2, 4'hf);
    wr(3'd3, 32'hFFFFFFFF, 4'hf);
    wr(3'd0, 32'h1, 4'hf);
    for (int i = 0; i < 7; i++) begin
      rd(3'd2, obs, oi);
      chk("presc_count", obs, exp_ps[i]);
    end

    rst_cyc();
    wr(3'd2, 32'hFFFFFFFF, 4'hf);
    wr(3'd3, 32'h5, 4'hf);
    wr(3'd0, 32'h1, 4'hf);
    rd(3'd2, obs, oi);
    chk("wrap_pre", obs, 32'hFFFFFFFF);
    rd(3'd2, obs, oi);
    chk("wrap_zero", obs, 32'h0);
    rd(3'd1, obs, oi);
    chk("wrap_nomatch", obs, 32'h0);
    for (int n = 0; n < 20 && m_count != 32'h5; n++) rd(3'd2, obs, oi);
    wr(3'd1, 32'h1, 4'hf);
    rd(3'd1, obs, oi);
    chk("w1c_collide", obs, 32'h1);
    wr(3'd1, 32'h1, 4'hf);
    rd(3'd1, obs, oi);
    chk("w1c_after", obs, 32'h0);

    wr(3'd2, 32'd100, 4'hf);
    rd(3'd2, obs, oi);
    chk("wr_prio", obs, 32'd100);
    rd(3'd2, obs, oi);
    chk("wr_prio_next", obs, 32'd101);
    begin
      logic [31:0] od;
      logic        o2;
      cyc(1, 1, {27'h0, 3'd2, 2'b00}, 4'hf, 32'd55, 1, od, o2);
    end
    for (int i = 0; i < 5; i++) begin
      rd(3'(i), obs, oi);
      chk("mid_reset", obs, 32'h0);
    end

    for (int k = 0; k < 400; k++) begin
      logic        c, w, r;
      logic [2:0]  a;
      logic [3:0]  s;
      logic [31:0] d, ad;
      r  = ($urandom_range(0, 59) == 0);
      c  = ($urandom_range(0, 3) != 0);
      w  = 1'($urandom_range(0, 1));
      a  = 3'($urandom_range(0, 7));
      s  = 4'($urandom);
      d  = $urandom;
      if (a == 3'd2 || a == 3'd3) d = $urandom_range(0, 12);
      if (a == 3'd4) begin
        d = $urandom_range(0, 3);
        if (m_ctrl[0]) w = 1'b0;
      end
      ad = ($urandom & ~32'h1c) | {27'h0, a, 2'b00};
      cyc(c, w, ad, s, d, r, obs, oi);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
